dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and lane controller in front of the single-port, byte-enabled data memory. Shares the memory between the CPU load/store path (port 0) and the program loader / DMA path (port 1) with round-robin fairness. Converts RISC-V funct3 size codes and byte address into word address, byte enables and aligned store data. Returns sign- or zero-extended load data one cycle after grant.

## Interface
- ADDR_WIDTH, 32, byte-address width of both requester ports
- MEM_AW, 10, word-address width to memory (memory depth 2^MEM_AW words)
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req0 / req1  input  1  request valid, per port
- we0 / we1  input  1  1 = store, 0 = load
- addr0 / addr1  input  ADDR_WIDTH  byte address
- wdata0 / wdata1  input  32  store data, LSB-justified
- funct3_0 / funct3_1  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- gnt0 / gnt1  output  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  output  1  response for request granted previous cycle
- rdata0 / rdata1  output  32  extended load data, valid with rvalid
- err0 / err1  output  1  misaligned or illegal funct3, valid with rvalid
- mem_en  output  1  memory access this cycle
- mem_we  output  1  write strobe
- mem_addr  output  MEM_AW  word address = addr[MEM_AW+1:2]
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-aligned store data
- mem_rdata  input  32  memory read data, valid cycle after mem_en with mem_we=0

## Operation
- Requester holds req, we, addr, wdata, funct3 stable until gnt; gnt high for one cycle per transaction.
- Arbitration: both idle -> nothing; one request -> grant it; both -> grant port not in `last` register; `last` updated to granted port on every grant.
- At most one grant per cycle; gnt0 & gnt1 never both high.
- Alignment check: h/hu need addr[0]=0; w needs addr[1:0]=00; funct3 011/110/111 illegal; stores allow only 000/001/010. Failed check: granted, mem_en stays 0, err pulsed with rvalid next cycle, rdata = 0.
- Byte enables: b -> 0001<<addr[1:0]; h -> 0011<<addr[1:0]; w -> 1111. Loads drive mem_be per the same rule (informational).
- Store data: b replicated to all four lanes, h replicated to both halves, w passed through.
- Response register captures {port, funct3, addr[1:0], err, is_load} at grant; next cycle extracts byte/half from mem_rdata by addr[1:0], sign-extends for b/h, zero-extends for bu/hu.
- Stores also return rvalid (rdata = 0) so both ports see a uniform completion.
- Non-granted port's rvalid/err stay 0.

## Timing
- Grant: same cycle as req (combinational from req and `last`).
- Memory command: same cycle as grant.
- Load latency: rvalid/rdata at T+1 for grant at T; back-to-back grants every cycle, full throughput.
- Reset: `last` = port 1 (port 0 wins first contention); rvalid0/1, err0/1 = 0; rdata0/1 = 0; response register invalid. gnt and mem_en driven 0 while rst high.
- Reset asserted while a response is pending: response dropped, no rvalid after reset.
- Simultaneous req0 and req1 on consecutive cycles: strict alternation 0,1,0,1.
- Request withdrawn without grant: illegal per protocol; no requirement.

## Structure
- Shared package mem_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), typedef resp_t for the response register.
- Sub-module load_align: combinational extraction/extension of mem_rdata by funct3 and byte offset; reused by later cache work.
- Top holds arbiter, `last` register, alignment check, store lane logic, response register.

## Test plan
- Reset, then req0 lw addr 0x10, mem word 0x8081_8283 -> gnt0 same cycle, mem_addr 4, rvalid0 next cycle, rdata0 0x8081_8283.
- req0 lb addr 0x11 then lbu addr 0x11, same word -> rdata0 0xFFFF_FF82 then 0x0000_0082.
- req0 sb wdata 0xAB addr 0x13 -> mem_be 1000, mem_wdata 0xABAB_ABAB, rvalid0 next cycle, err0 0.
- req0 and req1 held high for 4 cycles after reset -> grants 0,1,0,1; rvalid follows each grant by one cycle on correct port.
- req1 lw addr 0x06 -> gnt1, mem_en 0, err1 and rvalid1 next cycle, rdata1 0.
- Grant lw at T, rst high at T+1 -> no rvalid0 at or after T+1, all outputs 0 during reset.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: funct3 size codes and response register layout shared by the data memory path
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef struct packed {
    logic       valid;
    logic       port;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
    logic       is_load;
  } resp_t;
endpackage

// File: rtl/load_align.sv
// load_align: extract byte/half from a memory word by offset and sign- or zero-extend by funct3
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // pick the addressed lane, then extend according to the size code
  always_comb begin
    b    = rdata[{off, 3'b000} +: 8];
    h    = off[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_BU ? {24'b0, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and byte-lane controller for the data memory
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  logic                  last, sel1, any, we, err;
  logic [ADDR_WIDTH-1:0] a;
  logic [31:0]           wd, ext;
  logic [2:0]            f3;
  logic                  unused_addr;
  resp_t                 resp;
  assign unused_addr = ^{addr0, addr1};
  // arbitration, request mux, legality check and memory command
  always_comb begin
    sel1      = req1 & (~req0 | ~last);
    gnt1      = ~rst & sel1;
    gnt0      = ~rst & req0 & ~sel1;
    any       = gnt0 | gnt1;
    we        = sel1 ? we1 : we0;
    a         = sel1 ? addr1 : addr0;
    wd        = sel1 ? wdata1 : wdata0;
    f3        = sel1 ? funct3_1 : funct3_0;
    err       = f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]) ||
                (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    mem_en    = any & ~err;
    mem_we    = mem_en & we;
    mem_addr  = a[MEM_AW+1:2];
    mem_be    = f3[1:0] == 2'b10 ? 4'hF : (f3[0] ? 4'b0011 : 4'b0001) << a[1:0];
    mem_wdata = f3[1:0] == 2'b10 ? wd : f3[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
  end
  // arbitration history and one-deep response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
      resp <= '0;
    end else begin
      if (any) last <= gnt1;
      resp <= '{valid: any, port: gnt1, funct3: f3, off: a[1:0], err: err, is_load: ~we};
    end
  end
  load_align u_align (.rdata(mem_rdata), .funct3(resp.funct3), .off(resp.off), .data(ext));
  // steer the completion to the port that was granted; silence everything during reset
  always_comb begin
    rvalid0 = ~rst & resp.valid & ~resp.port;
    rvalid1 = ~rst & resp.valid & resp.port;
    err0    = rvalid0 & resp.err;
    err1    = rvalid1 & resp.err;
    rdata0  = rvalid0 & resp.is_load & ~resp.err ? ext : 32'b0;
    rdata1  = rvalid1 & resp.is_load & ~resp.err ? ext : 32'b0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, lane control and load extension
module tb_dmem_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [2:0]  funct3_0 = 0, funct3_1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem [0:1023];
  int          errors = 0, checks = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .funct3_0(funct3_0), .funct3_1(funct3_1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic p0(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    req0 = 1; we0 = we; addr0 = a; wdata0 = wd; funct3_0 = f3;
  endtask

  task automatic p1(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    req1 = 1; we1 = we; addr1 = a; wdata1 = wd; funct3_1 = f3;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8081_8283;
    mem[8] = 32'h1122_3344;
    mem_rdata = 0;
    p0(0, 32'h10, 0, 3'b010);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    @(negedge clk);
    rst = 0;
    // lw 0x10
    p0(0, 32'h10, 0, 3'b010);
    #1;
    chk("lw_gnt0", gnt0, 1);
    chk("lw_gnt1", gnt1, 0);
    chk("lw_mem_en", mem_en, 1);
    chk("lw_mem_addr", mem_addr, 4);
    chk("lw_mem_be", mem_be, 4'hF);
    @(posedge clk); #1;
    chk("lw_rvalid0", rvalid0, 1);
    chk("lw_rdata0", rdata0, 32'h8081_8283);
    chk("lw_err0", err0, 0);
    chk("lw_rvalid1", rvalid1, 0);
    // lb / lbu 0x11
    @(negedge clk);
    p0(0, 32'h11, 0, 3'b000);
    #1;
    chk("lb_mem_be", mem_be, 4'b0010);
    @(posedge clk); #1;
    chk("lb_rdata0", rdata0, 32'hFFFF_FF82);
    @(negedge clk);
    p0(0, 32'h11, 0, 3'b100);
    @(posedge clk); #1;
    chk("lbu_rdata0", rdata0, 32'h0000_0082);
    // lh 0x12 (0x8081 sign-extended)
    @(negedge clk);
    p0(0, 32'h12, 0, 3'b001);
    #1;
    chk("lh_mem_be", mem_be, 4'b1100);
    @(posedge clk); #1;
    chk("lh_rdata0", rdata0, 32'hFFFF_8081);
    // sb 0xAB to 0x13
    @(negedge clk);
    p0(1, 32'h13, 32'h0000_00AB, 3'b000);
    #1;
    chk("sb_mem_be", mem_be, 4'b1000);
    chk("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_mem_we", mem_we, 1);
    @(posedge clk); #1;
    chk("sb_rvalid0", rvalid0, 1);
    chk("sb_err0", err0, 0);
    chk("sb_rdata0", rdata0, 0);
    // sh 0x1234 to 0x20 (half replicated)
    @(negedge clk);
    p0(1, 32'h20, 32'hFFFF_1234, 3'b001);
    #1;
    chk("sh_mem_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_mem_be", mem_be, 4'b0011);
    @(negedge clk);
    p0(0, 32'h10, 0, 3'b010);
    @(posedge clk); #1;
    chk("lw_after_sb", rdata0, 32'hAB81_8283);
    @(negedge clk);
    p0(0, 32'h20, 0, 3'b010);
    @(posedge clk); #1;
    chk("lw_after_sh", rdata0, 32'h1122_1234);
    // contention after reset: 0,1,0,1
    @(negedge clk);
    req0 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    p0(0, 32'h10, 0, 3'b010);
    p1(0, 32'h20, 0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr_rvalid0_%0d", i), rvalid0, (i % 2 == 0));
      chk($sformatf("rr_rvalid1_%0d", i), rvalid1, (i % 2 == 1));
      chk($sformatf("rr_rdata_%0d", i), (i % 2 == 0) ? rdata0 : rdata1,
          (i % 2 == 0) ? 32'hAB81_8283 : 32'h1122_1234);
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
    // misaligned lw on port 1
    p1(0, 32'h06, 0, 3'b010);
    #1;
    chk("mis_gnt1", gnt1, 1);
    chk("mis_mem_en", mem_en, 0);
    @(posedge clk); #1;
    chk("mis_rvalid1", rvalid1, 1);
    chk("mis_err1", err1, 1);
    chk("mis_rdata1", rdata1, 0);
    chk("mis_rvalid0", rvalid0, 0);
    // illegal funct3 011 and store with unsigned code
    @(negedge clk);
    req1 = 0;
    p0(0, 32'h10, 0, 3'b011);
    #1;
    chk("ill_mem_en", mem_en, 0);
    @(posedge clk); #1;
    chk("ill_err0", err0, 1);
    @(negedge clk);
    p0(1, 32'h10, 32'h55, 3'b100);
    #1;
    chk("stu_mem_en", mem_en, 0);
    @(posedge clk); #1;
    chk("stu_err0", err0, 1);
    chk("stu_err1", err1, 0);
    // reset while a load response is pending
    @(negedge clk);
    p0(0, 32'h10, 0, 3'b010);
    #1;
    chk("pend_gnt0", gnt0, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("pend_rvalid0", rvalid0, 0);
    chk("pend_rdata0", rdata0, 0);
    chk("pend_err0", err0, 0);
    chk("pend_gnt0_rst", gnt0, 0);
    chk("pend_mem_en_rst", mem_en, 0);
    @(posedge clk); #1;
    chk("pend_rvalid0_after", rvalid0, 0);
    @(negedge clk);
    rst = 0; req0 = 0;
    @(posedge clk); #1;
    chk("pend_rvalid0_post", rvalid0, 0);
    chk("pend_rvalid1_post", rvalid1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
